// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 (poly 0x8005, init 0xFFFF) for the USB receive path.
// The register is exposed raw and freezes on end-of-packet until re-armed.
module crc16_serial_checker (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        shift_enable,
  input  logic        serial_in,
  input  logic        eop,
  input  logic        crc_rcv,
  output logic        shift_stop,
  output logic [15:0] parallel_out
);

  localparam logic [15:0] POLY = 16'h8005;
  localparam logic [15:0] INIT = 16'hFFFF;

  logic [15:0] r_crc;
  logic        r_stop;
  logic        w_fb;
  logic [15:0] w_next;

  assign w_fb   = serial_in ^ r_crc[15];
  assign w_next = {r_crc[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);

  // The eop bit itself is never shifted; once frozen only reset or crc_rcv low can re-arm.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_crc  <= INIT;
      r_stop <= 1'b0;
    end else if (!crc_rcv) begin
      r_crc  <= INIT;
      r_stop <= 1'b0;
    end else if (r_stop) begin
      r_crc  <= r_crc;
      r_stop <= r_stop;
    end else if (eop) begin
      r_crc  <= r_crc;
      r_stop <= 1'b1;
    end else if (shift_enable) begin
      r_crc  <= w_next;
      r_stop <= 1'b0;
    end else begin
      r_crc  <= r_crc;
      r_stop <= r_stop;
    end
  end

  assign parallel_out = r_crc;
  assign shift_stop   = r_stop;

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Self-checking bench for crc16_serial_checker: directed USB CRC cases plus
// randomized traffic against a polynomial long-division reference model.
module tb_crc16_serial_checker;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        shift_enable;
  logic        serial_in;
  logic        eop;
  logic        crc_rcv;
  logic        shift_stop;
  logic [15:0] parallel_out;

  int passCount  = 0;
  int checkCount = 0;

  bit modelBits[$];
  bit modelFrozen;

  crc16_serial_checker dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .eop          (eop),
    .crc_rcv      (crc_rcv),
    .shift_stop   (shift_stop),
    .parallel_out (parallel_out)
  );

  always #5 clk = ~clk;

  // Remainder of (0xFFFF * x^n + M(x) * x^16) mod (x^16+x^15+x^2+1) by textbook long division.
  function automatic logic [15:0] refCrc(input bit msg[$]);
    int n;
    bit d[];
    logic [16:0] gen;
    logic [15:0] rem;
    n   = msg.size();
    gen = 17'h18005;
    d   = new[n + 16];
    for (int i = 0; i < n + 16; i++) d[i] = 1'b0;
    for (int i = 0; i < n; i++) d[i] = msg[i];
    for (int i = 0; i < 16; i++) d[i] = d[i] ^ 1'b1;
    for (int i = 0; i < n; i++)
      if (d[i])
        for (int j = 0; j <= 16; j++) d[i + j] = d[i + j] ^ gen[16 - j];
    for (int j = 0; j < 16; j++) rem[15 - j] = d[n + j];
    return rem;
  endfunction

  task automatic cycle(input logic se, input logic si, input logic e,
                       input logic rcv, input logic rst);
    shift_enable = se;
    serial_in    = si;
    eop          = e;
    crc_rcv      = rcv;
    n_rst        = rst;
    @(posedge clk);
    #1;
    if (rst || !rcv) begin
      modelBits.delete();
      modelFrozen = 1'b0;
    end else if (!modelFrozen) begin
      if (e) modelFrozen = 1'b1;
      else if (se) modelBits.push_back(si);
    end
  endtask

  task automatic shiftBits(input logic si, input int count);
    for (int i = 0; i < count; i++) cycle(1'b1, si, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkCount++;
    if (parallel_out !== 16'hFFFF) $display("[TB] FAIL reset_crc: got %h expected ffff", parallel_out);
    else passCount++;
    checkCount++;
    if (shift_stop !== 1'b0) $display("[TB] FAIL reset_stop: got %b expected 0", shift_stop);
    else passCount++;
    shiftBits(1'b1, 5);
    shiftBits(1'b0, 3);
    checkCount++;
    if (parallel_out !== refCrc(modelBits))
      $display("[TB] FAIL reset_partial: got %h expected %h", parallel_out, refCrc(modelBits));
    else passCount++;
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkCount++;
    if (parallel_out !== 16'hFFFF) $display("[TB] FAIL reset_midstream: got %h expected ffff", parallel_out);
    else passCount++;
  endtask

  task automatic test_generate();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    shiftBits(1'b1, 16);
    checkCount++;
    if (parallel_out !== 16'h0000) $display("[TB] FAIL gen_ones: got %h expected 0000", parallel_out);
    else passCount++;
    checkCount++;
    if (~parallel_out !== 16'hFFFF) $display("[TB] FAIL gen_txcrc: got %h expected ffff", ~parallel_out);
    else passCount++;
    shiftBits(1'b0, 16);
    checkCount++;
    if (parallel_out !== 16'h0000) $display("[TB] FAIL gen_zeros: got %h expected 0000", parallel_out);
    else passCount++;
  endtask

  task automatic test_empty_payload();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    shiftBits(1'b0, 16);
    checkCount++;
    if (parallel_out !== 16'h800D) $display("[TB] FAIL empty_payload: got %h expected 800d", parallel_out);
    else passCount++;
  endtask

  task automatic test_good_packet();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    shiftBits(1'b1, 32);
    checkCount++;
    if (parallel_out !== 16'h800D) $display("[TB] FAIL good_residual: got %h expected 800d", parallel_out);
    else passCount++;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCount++;
    if (shift_stop !== 1'b1) $display("[TB] FAIL good_stop: got %b expected 1", shift_stop);
    else passCount++;
    checkCount++;
    if (parallel_out !== 16'h800D) $display("[TB] FAIL good_eop_hold: got %h expected 800d", parallel_out);
    else passCount++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, logic'(i % 2), logic'(i == 3), 1'b1, 1'b0);
      checkCount++;
      if (parallel_out !== 16'h800D || shift_stop !== 1'b1)
        $display("[TB] FAIL good_frozen[%0d]: got %h/%b expected 800d/1", i, parallel_out, shift_stop);
      else passCount++;
    end
  endtask

  task automatic test_bad_packet();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    shiftBits(1'b1, 31);
    shiftBits(1'b0, 1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkCount++;
    if (parallel_out === 16'h800D || parallel_out !== refCrc(modelBits))
      $display("[TB] FAIL bad_residual: got %h expected %h (not 800d)", parallel_out, refCrc(modelBits));
    else passCount++;
    checkCount++;
    if (shift_stop !== 1'b1) $display("[TB] FAIL bad_stop: got %b expected 1", shift_stop);
    else passCount++;
  endtask

  task automatic test_rearm();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCount++;
    if (parallel_out !== 16'hFFFF || shift_stop !== 1'b0)
      $display("[TB] FAIL rearm_init: got %h/%b expected ffff/0", parallel_out, shift_stop);
    else passCount++;
    shiftBits(1'b0, 16);
    checkCount++;
    if (parallel_out !== 16'h800D) $display("[TB] FAIL rearm_empty: got %h expected 800d", parallel_out);
    else passCount++;
  endtask

  task automatic test_roundtrip();
    int len;
    logic [15:0] txCrc;
    for (int p = 0; p < 6; p++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) cycle(1'b1, logic'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      txCrc = ~refCrc(modelBits);
      for (int b = 15; b >= 0; b--) cycle(1'b1, txCrc[b], 1'b0, 1'b1, 1'b0);
      checkCount++;
      if (parallel_out !== 16'h800D)
        $display("[TB] FAIL roundtrip[%0d]: got %h expected 800d", p, parallel_out);
      else passCount++;
    end
  endtask

  task automatic test_random();
    logic se, si, e, rcv, rst;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      se  = logic'($urandom_range(0, 3) != 0);
      si  = logic'($urandom_range(0, 1));
      e   = logic'($urandom_range(0, 39) == 0);
      rcv = logic'($urandom_range(0, 59) != 0);
      rst = logic'($urandom_range(0, 149) == 0);
      cycle(se, si, e, rcv, rst);
      checkCount++;
      if (parallel_out !== refCrc(modelBits) || shift_stop !== modelFrozen)
        $display("[TB] FAIL random[%0d]: got %h/%b expected %h/%b",
                 i, parallel_out, shift_stop, refCrc(modelBits), modelFrozen);
      else passCount++;
    end
  endtask

  initial begin
    n_rst        = 1'b1;
    shift_enable = 1'b0;
    serial_in    = 1'b0;
    eop          = 1'b0;
    crc_rcv      = 1'b1;
    modelFrozen  = 1'b0;
    test_reset();
    test_generate();
    test_empty_payload();
    test_good_packet();
    test_bad_packet();
    test_rearm();
    test_roundtrip();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/crc16_serial_checker.md
Name: crc16_serial_checker

Overview:
- Serial CRC-16 engine for the USB receive path. It implements polynomial x^16+x^15+x^2+1 (0x8005), with the shift register initialised to all ones.
- It shifts one received bit per enabled cycle and exposes the raw register in parallel.
- On end-of-packet it freezes, so downstream logic can compare parallel_out against the USB good-CRC residual 0x800D.
- It sits between the bit-unstuffing/decode stage and the packet-validation logic.

Parameters:
- None. Width (16), polynomial (0x8005), init value (0xFFFF) and residual (0x800D) are fixed constants.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  synchronous, active-high reset. The port keeps the codebase reset name, but a 1 sampled on a rising edge resets the block.
- shift_enable  input  1  qualifies serial_in; one bit is consumed per rising edge while high.
- serial_in  input  1  received data bit, MSB-of-polynomial-first Galois order.
- eop  input  1  end-of-packet strobe; freezes the register.
- crc_rcv  input  1  packet-active qualifier. While low, the block is held in its initial state (re-arm between packets without reset).
- shift_stop  output  1  registered; high while the register is frozen after eop.
- parallel_out  output  16  current CRC register contents, driven directly from the register.

Behaviour:
- State: 16-bit register R and 1-bit flag S (S drives shift_stop). parallel_out = R combinationally.
- Evaluate the following on each rising edge, in priority order:
  1. n_rst=1: R<=0xFFFF, S<=0.
  2. crc_rcv=0: R<=0xFFFF, S<=0.
  3. S=1: hold R and S. shift_enable and eop are ignored until reset or crc_rcv low.
  4. eop=1: S<=1 and R holds. The bit on serial_in in the eop cycle is not shifted, even if shift_enable=1.
  5. shift_enable=1: fb = serial_in XOR R[15]; R <= {R[14:0],1'b0} XOR (fb ? 0x8005 : 0x0000).
  6. Otherwise: hold.
- Latency: each shifted bit is reflected in parallel_out after the same edge that consumed it. shift_stop rises on the edge that samples eop.
- CRC generation: after a payload has been shifted, the transmit CRC is ~R, sent bit 15 first.
- CRC checking: after payload plus received CRC have been shifted, R==0x800D means good and any other value means bad. The comparison is done by the consumer, not in this block.
- Reset or crc_rcv low mid-packet discards all accumulated state immediately, with no partial freeze.
- Outputs after reset: parallel_out=0xFFFF, shift_stop=0.
- No handshake. The upstream stage guarantees one valid bit per shift_enable cycle.

Test Plan:
- Reset behaviour: assert n_rst for 1 cycle with shift_enable=1 and serial_in=1 -> after release parallel_out=0xFFFF and shift_stop=0. Repeating the pulse mid-stream also returns 0xFFFF.
- Generate, all-ones payload: crc_rcv=1, shift 16 ones -> parallel_out=0x0000, so the transmit CRC is 0xFFFF. Then shift 16 further zeros -> parallel_out stays 0x0000.
- Empty-payload check: from reset, shift 16 zeros (the CRC of an empty payload) -> parallel_out=0x800D.
- Good-packet check: shift 16 ones then CRC 0xFFFF (16 more ones) -> parallel_out=0x800D. Pulse eop one cycle with serial_in=0 -> shift_stop=1 and parallel_out stays 0x800D for all later cycles despite shift_enable=1 and toggling serial_in.
- Bad-packet check: as the good-packet case but flip the last CRC bit to 0 -> parallel_out != 0x800D after eop, and shift_stop=1.
- Re-arm: after a frozen packet, drive crc_rcv=0 for one cycle -> parallel_out=0xFFFF and shift_stop=0. Then 16 zeros -> 0x800D.
